// File: rtl/sbox_inv_pipe_if.sv
// Valid/ready stream carrying one 64-bit bitsliced state per transfer.
// The producer drives valid/data, the consumer drives ready.
`timescale 1ns/1ps

interface sbox_inv_pipe_if;
    logic        valid;
    logic        ready;
    logic [63:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sbox_inv_pipe.sv
// Elastic pipelined inverse of the TGIF bitsliced 4-bit S-box layer.
// Four 16-bit slices; each bit column is one independent S-box instance.
`timescale 1ns/1ps

module sbox_inv_pipe #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    sbox_inv_pipe_if.slave  s,
    sbox_inv_pipe_if.master m
);

    // First half of the inverse: y -> {t0, t1, t2, t3}
    function automatic logic [63:0] inv_front(input logic [63:0] y);
        logic [15:0] t0, t1, t2, t3;
        t3 = ~y[63:48];
        t1 = y[15:0];
        t0 = y[47:32] ^ t3;
        t2 = y[31:16] ^ (y[15:0] & y[47:32]);
        return {t0, t1, t2, t3};
    endfunction

    function automatic logic [63:0] inv_back(input logic [63:0] t);
        logic [15:0] t0, t1, t2, t3, a, b, c, d;
        t0 = t[63:48];
        t1 = t[47:32];
        t2 = t[31:16];
        t3 = t[15:0];
        d  = t3 ^ t2;
        c  = t2 ^ (t1 | t0);
        a  = t1 ^ (t0 & d);
        b  = t0 ^ (a & c);
        return {a, b, c, d};
    endfunction

    logic        out_valid;
    logic [63:0] out_data;
    logic        en_out;
    logic        last_valid;
    logic [63:0] last_t;

    assign en_out  = ~out_valid | m.ready;
    assign m.valid = out_valid;
    assign m.data  = out_data;

    // Output stage: data only moves when a valid block is loaded, so idle cycles keep m_data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 64'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (en_out) begin
            out_valid <= last_valid;
            if (last_valid) begin
                out_data <= inv_back(last_t);
            end
        end
    end

    generate
        if (STAGES == 2) begin : g_two
            logic        v1;
            logic [63:0] st1;
            logic        en1;

            assign en1        = ~v1 | en_out;
            assign s.ready    = en1 & ~flush;
            assign last_valid = v1;
            assign last_t     = st1;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v1  <= 1'b0;
                    st1 <= 64'd0;
                end else if (flush) begin
                    v1 <= 1'b0;
                end else if (en1) begin
                    v1 <= s.valid;
                    if (s.valid) begin
                        st1 <= inv_front(s.data);
                    end
                end
            end
        end else if (STAGES == 1) begin : g_one
            assign s.ready    = en_out & ~flush;
            assign last_valid = s.valid;
            assign last_t     = inv_front(s.data);
        end else begin : g_bad
            $error("sbox_inv_pipe: STAGES must be 1 or 2");
            assign s.ready    = 1'b0;
            assign last_valid = 1'b0;
            assign last_t     = 64'd0;
        end
    endgenerate

endmodule

// File: tb/tb_sbox_inv_pipe.sv
// Scoreboard bench for sbox_inv_pipe: runs the same scenarios on a STAGES=2
// and a STAGES=1 instance, selected one at a time.
`timescale 1ns/1ps

module tb_sbox_inv_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        drv_valid = 1'b0;
    logic        drv_mready = 1'b0;
    logic [63:0] drv_data = 64'd0;
    logic [63:0] drv_exp = 64'd0;
    int          sel = 2;
    int          cur_stages = 2;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] q[$];

    logic        obs_s_ready;
    logic        obs_m_valid;
    logic [63:0] obs_m_data;

    sbox_inv_pipe_if in2 ();
    sbox_inv_pipe_if out2 ();
    sbox_inv_pipe_if in1 ();
    sbox_inv_pipe_if out1 ();

    assign in2.valid  = drv_valid & (sel == 2);
    assign in2.data   = drv_data;
    assign out2.ready = drv_mready;
    assign in1.valid  = drv_valid & (sel == 1);
    assign in1.data   = drv_data;
    assign out1.ready = drv_mready;

    assign obs_s_ready = (sel == 2) ? in2.ready  : in1.ready;
    assign obs_m_valid = (sel == 2) ? out2.valid : out1.valid;
    assign obs_m_data  = (sel == 2) ? out2.data  : out1.data;

    sbox_inv_pipe #(.STAGES(2)) dut2 (.clk(clk), .rst(rst), .flush(flush), .s(in2.slave), .m(out2.master));
    sbox_inv_pipe #(.STAGES(1)) dut1 (.clk(clk), .rst(rst), .flush(flush), .s(in1.slave), .m(out1.master));

    always #5 clk = ~clk;

    // Forward S-box, derived by solving the inverse equations backwards
    function automatic logic [63:0] fwd(input logic [63:0] x);
        logic [15:0] a, b, c, d, t0, t1, t2, t3, y0, y1, y2, y3;
        {a, b, c, d} = x;
        t0 = b ^ (a & c);
        t1 = a ^ (t0 & d);
        t2 = c ^ (t1 | t0);
        t3 = d ^ t2;
        y0 = ~t3;
        y3 = t1;
        y1 = t0 ^ t3;
        y2 = t2 ^ (y3 & y1);
        return {y0, y1, y2, y3};
    endfunction

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s (stages=%0d): got %h expected %h", tag, cur_stages, got, exp);
        end
    endtask

    // Monitor: push on input handshake, pop and compare on output handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (flush) begin
                q.delete();
            end else begin
                if (obs_m_valid && drv_mready) begin
                    if (q.size() > 0) check_output("data", obs_m_data, q.pop_front());
                    else check_output("spurious", {63'd0, obs_m_valid}, 64'd0);
                end
                if (drv_valid && obs_s_ready) q.push_back(drv_exp);
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        drv_valid = 1'b0;
        drv_mready = 1'b0;
        flush = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_mvalid", {63'd0, obs_m_valid}, 64'd0);
        check_output("rst_mdata", obs_m_data, 64'd0);
        check_output("rst_sready", {63'd0, obs_s_ready}, 64'd1);
    endtask

    task automatic send_one(input logic [63:0] y, input logic [63:0] x);
        int n;
        @(posedge clk); #1;
        drv_mready = 1'b1;
        drv_valid = 1'b1;
        drv_data = y;
        drv_exp = x;
        @(negedge clk);
        check_output("accept", {63'd0, obs_s_ready}, 64'd1);
        @(posedge clk); #1;
        drv_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!obs_m_valid && n < 8);
        check_output("latency", 64'(n), 64'(cur_stages));
        repeat (2) @(posedge clk);
    endtask

    task automatic apply_stimulus_random();
        logic [63:0] x;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            x = {$urandom, $urandom};
            drv_mready = 1'b1;
            drv_valid = 1'b1;
            drv_data = fwd(x);
            drv_exp = x;
            @(negedge clk);
            check_output("stream_ready", {63'd0, obs_s_ready}, 64'd1);
            if (i >= cur_stages) check_output("no_bubble", {63'd0, obs_m_valid}, 64'd1);
        end
        @(posedge clk); #1;
        drv_valid = 1'b0;
        repeat (4) @(posedge clk);
        check_output("stream_drain", 64'(q.size()), 64'd0);
    endtask

    task automatic apply_stimulus_backpressure();
        logic [63:0] blk[5];
        logic [63:0] held;
        bit          have_held;
        int          idx;
        for (int i = 0; i < 5; i++) blk[i] = {$urandom, $urandom};
        idx = 0;
        have_held = 0;
        held = 64'd0;
        for (int cyc = 0; cyc < 40 && (idx < 5 || q.size() > 0); cyc++) begin
            @(posedge clk); #1;
            drv_mready = (cyc >= 4);
            drv_valid = (idx < 5);
            drv_data = fwd(blk[idx < 5 ? idx : 4]);
            drv_exp = blk[idx < 5 ? idx : 4];
            @(negedge clk);
            if (cyc < 4) begin
                check_output("bp_ready", {63'd0, obs_s_ready}, {63'd0, cyc < cur_stages});
                if (cyc >= cur_stages) check_output("bp_mvalid", {63'd0, obs_m_valid}, 64'd1);
                if (obs_m_valid) begin
                    if (have_held) check_output("bp_stable", obs_m_data, held);
                    held = obs_m_data;
                    have_held = 1;
                end
            end
            if (drv_valid && obs_s_ready) idx++;
        end
        @(posedge clk); #1;
        drv_valid = 1'b0;
        check_output("bp_count", 64'(idx), 64'd5);
        check_output("bp_drain", 64'(q.size()), 64'd0);
    endtask

    task automatic apply_stimulus_flush();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            drv_mready = 1'b0;
            drv_valid = 1'b1;
            drv_data = fwd(64'h1111_2222_3333_4444 + 64'(i));
            drv_exp = 64'h1111_2222_3333_4444 + 64'(i);
        end
        @(posedge clk); #1;
        flush = 1'b1;
        drv_data = fwd(64'hDEAD_BEEF_0000_0001);
        drv_exp = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        check_output("flush_sready", {63'd0, obs_s_ready}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        drv_valid = 1'b0;
        drv_mready = 1'b1;
        @(negedge clk);
        check_output("flush_mvalid", {63'd0, obs_m_valid}, 64'd0);
        repeat (4) @(posedge clk);
        check_output("flush_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic apply_stimulus_reset_mid();
        int n;
        @(posedge clk); #1;
        drv_mready = 1'b0;
        drv_valid = 1'b1;
        drv_data = fwd(64'h0123_4567_89AB_CDEF);
        drv_exp = 64'h0123_4567_89AB_CDEF;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        n = 0;
        while (!obs_m_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check_output("rstmid_setup", {63'd0, obs_m_valid}, 64'd1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        q.delete();
        check_output("rstmid_mvalid", {63'd0, obs_m_valid}, 64'd0);
        check_output("rstmid_mdata", obs_m_data, 64'd0);
        check_output("rstmid_sready", {63'd0, obs_s_ready}, 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        send_one(64'hFFFF_0000_0000_0000, 64'h0000_0000_0000_0000);
        check_output("rstmid_drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            sel = (k == 0) ? 2 : 1;
            cur_stages = sel;
            apply_reset();
            send_one(64'hFFFF_0000_0000_0000, 64'h0000_0000_0000_0000);
            send_one(64'h0000_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
            send_one(64'h0000_FFFF_0000_FFFF, 64'hFFFF_0000_0000_0000);
            check_output("directed_drain", 64'(q.size()), 64'd0);
            apply_stimulus_random();
            apply_stimulus_backpressure();
            apply_stimulus_flush();
            apply_stimulus_reset_mid();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
